// File: rtl/segre_lsu_pkg.sv
// rtl/segre_lsu_pkg.sv - shared types and constants for the load/store unit
package segre_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  localparam int MEM_BE_WIDTH = 4;

endpackage

// File: rtl/segre_lsu_align.sv
// rtl/segre_lsu_align.sv - byte-lane steering for stores and load extraction/extension
module segre_lsu_align
  import segre_lsu_pkg::*;
(
  input  memop_data_type_e        data_type,
  input  logic [1:0]              offset,
  input  logic                    sign_ext,
  input  logic [31:0]             wdata,
  input  logic [31:0]             rdata,
  output logic [MEM_BE_WIDTH-1:0] be,
  output logic [31:0]             wdata_rep,
  output logic [31:0]             rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    case (data_type)
      BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/segre_lsu.sv
// rtl/segre_lsu.sv - memory-stage load/store unit with req/gnt/rvalid data-memory handshake
module segre_lsu
  import segre_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_SIZE   = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic                    memop_rd_i,
  input  logic                    memop_wr_i,
  input  memop_data_type_e        memop_type_i,
  input  logic                    memop_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [REG_SIZE-1:0]     rd_addr_i,
  output logic                    ready_o,
  output logic                    stall_o,
  output logic                    done_o,
  output logic                    misaligned_o,
  output logic                    rf_we_o,
  output logic [REG_SIZE-1:0]     rf_waddr_o,
  output logic [DATA_WIDTH-1:0]   rf_wdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [MEM_BE_WIDTH-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  lsu_state_e              state_q, state_d;
  memop_data_type_e        type_q;
  logic                    sign_ext_q, we_q, mis_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [REG_SIZE-1:0]     rd_addr_q;

  logic                    accept, mis_in, rdata_take;
  logic [MEM_BE_WIDTH-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata_rep, rdata_ext;

  assign accept     = (state_q == IDLE) && valid_i && (memop_rd_i || memop_wr_i);
  assign mis_in     = ((memop_type_i == HALF) && addr_i[0]) ||
                      ((memop_type_i == WORD) && (addr_i[1:0] != 2'b00));
  assign rdata_take = mem_rvalid_i &&
                      (((state_q == REQ) && mem_gnt_i) || (state_q == WAIT));

  segre_lsu_align u_align (
    .data_type (type_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (sign_ext_q),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q     <= BYTE;
      sign_ext_q <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        type_q     <= memop_type_i;
        sign_ext_q <= memop_sign_ext_i;
        // a memop flagged both rd and wr is treated as a load
        we_q       <= memop_wr_i & ~memop_rd_i;
        mis_q      <= mis_in;
        addr_q     <= addr_i;
        wdata_q    <= wdata_i;
        rd_addr_q  <= rd_addr_i;
      end
      if (rdata_take) rdata_q <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = mis_in ? RESP : REQ;
      REQ:     if (mem_gnt_i) state_d = mem_rvalid_i ? RESP : WAIT;
      WAIT:    if (mem_rvalid_i) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // memory-side outputs are zeroed outside REQ so nothing leaks while idle
  always_comb begin
    ready_o      = (state_q == IDLE);
    stall_o      = (state_q != IDLE);
    done_o       = (state_q == RESP);
    misaligned_o = (state_q == RESP) && mis_q;
    rf_we_o      = (state_q == RESP) && !mis_q && !we_q;
    rf_waddr_o   = rf_we_o ? rd_addr_q : '0;
    rf_wdata_o   = rf_we_o ? rdata_ext : '0;
    mem_req_o    = (state_q == REQ);
    mem_we_o     = mem_req_o && we_q;
    mem_be_o     = mem_req_o ? be : '0;
    mem_addr_o   = mem_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_wdata_o  = mem_req_o ? wdata_rep : '0;
  end

endmodule

// File: tb/tb_segre_lsu.sv
// tb/tb_segre_lsu.sv - scoreboard bench for segre_lsu
module tb_segre_lsu;
  import segre_lsu_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0, rd = 1'b0, wr = 1'b0, sx = 1'b0;
  memop_data_type_e mtype = BYTE;
  logic [31:0]      addr = '0, wdata = '0;
  logic [4:0]       rd_addr = '0;
  logic             ready, stall, done, mis, rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0;
  logic [3:0]       mem_be;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        mis;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } exp_t;
  exp_t sb[$];

  segre_lsu dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .memop_rd_i(rd), .memop_wr_i(wr),
    .memop_type_i(mtype), .memop_sign_ext_i(sx), .addr_i(addr), .wdata_i(wdata),
    .rd_addr_i(rd_addr), .ready_o(ready), .stall_o(stall), .done_o(done),
    .misaligned_o(mis), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one memop, play the memory side, then check the response against the scoreboard.
  task automatic run_op(input logic l_rd, input logic l_wr, input memop_data_type_e t,
                        input logic l_sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rda, input logic [31:0] rdata,
                        input int gnt_wait, input bit same, input exp_t e);
    exp_t x;
    sb.push_back(e);
    valid = 1'b1; rd = l_rd; wr = l_wr; mtype = t; sx = l_sx;
    addr = a; wdata = wd; rd_addr = rda;
    step();
    valid = 1'b0; rd = 1'b0; wr = 1'b0;
    if (!e.mis) begin
      for (int i = 0; i <= gnt_wait; i++) begin
        if (i == gnt_wait) begin
          mem_gnt = 1'b1; mem_rvalid = same; mem_rdata = rdata;
        end
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== e.we || mem_be !== e.be ||
            mem_addr !== e.maddr || mem_wdata !== e.mwdata) begin
          miscompares++;
          $display("FAIL req_fields: req=%b we=%b be=%h addr=%h wdata=%h want 1 %b %h %h %h",
                   mem_req, mem_we, mem_be, mem_addr, mem_wdata, e.we, e.be, e.maddr, e.mwdata);
        end
        step();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!same) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL wait_state: req=%b done=%b want 0 0", mem_req, done);
        end
        step();
        mem_rvalid = 1'b0;
      end
    end
    mem_rdata = 32'hxxxx_xxxx;
    @(negedge clk);
    x = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || mis !== x.mis || rf_we !== x.rf_we || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_flags: done=%b mis=%b rf_we=%b req=%b want 1 %b %b 0",
               done, mis, rf_we, mem_req, x.mis, x.rf_we);
    end
    if (x.rf_we) begin
      vectors++;
      if (rf_waddr !== x.waddr || rf_wdata !== x.wdata) begin
        miscompares++;
        $display("FAIL load_data: waddr=%0d wdata=%h want %0d %h", rf_waddr, rf_wdata, x.waddr, x.wdata);
      end
    end
    step();
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || mis !== 1'b0 || rf_we !== 1'b0 || ready !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL post_resp: done=%b mis=%b rf_we=%b ready=%b stall=%b want 0 0 0 1 0",
               done, mis, rf_we, ready, stall);
    end
  endtask

  function automatic exp_t mk(input logic m, input logic w, input logic [4:0] wa,
                              input logic [31:0] wdt, input logic we, input logic [3:0] be,
                              input logic [31:0] ma, input logic [31:0] mwd);
    exp_t e;
    e.mis = m; e.rf_we = w; e.waddr = wa; e.wdata = wdt;
    e.we = we; e.be = be; e.maddr = ma; e.mwdata = mwd;
    return e;
  endfunction

  task automatic test_reset();
    #2;
    vectors++;
    if (ready !== 1'b1 || stall !== 1'b0 || done !== 1'b0 || mis !== 1'b0 || rf_we !== 1'b0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_be !== 4'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b done=%b req=%b be=%h addr=%h", ready, done, mem_req, mem_be, mem_addr);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    run_op(1'b0, 1'b1, WORD, 1'b0, 32'h104, 32'hDEADBEEF, 5'd3, 32'h0, 2, 1'b0,
           mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 4'hF, 32'h104, 32'hDEADBEEF));
  endtask

  task automatic test_load_byte();
    run_op(1'b1, 1'b0, BYTE, 1'b1, 32'h203, 32'h0, 5'd7, 32'h80FF1234, 0, 1'b0,
           mk(1'b0, 1'b1, 5'd7, 32'hFFFFFF80, 1'b0, 4'b1000, 32'h200, 32'h0));
    run_op(1'b1, 1'b0, BYTE, 1'b0, 32'h203, 32'h0, 5'd8, 32'h80FF1234, 1, 1'b0,
           mk(1'b0, 1'b1, 5'd8, 32'h00000080, 1'b0, 4'b1000, 32'h200, 32'h0));
    // rd and wr both set behaves as a load
    run_op(1'b1, 1'b1, BYTE, 1'b0, 32'h201, 32'h55, 5'd9, 32'h80FF1234, 0, 1'b1,
           mk(1'b0, 1'b1, 5'd9, 32'h00000012, 1'b0, 4'b0010, 32'h200, 32'h55555555));
  endtask

  task automatic test_load_half_same_cycle();
    run_op(1'b1, 1'b0, HALF, 1'b0, 32'h202, 32'h0, 5'd10, 32'hBEEF0000, 0, 1'b1,
           mk(1'b0, 1'b1, 5'd10, 32'h0000BEEF, 1'b0, 4'b1100, 32'h200, 32'h0));
    run_op(1'b1, 1'b0, HALF, 1'b1, 32'h200, 32'h0, 5'd11, 32'h12348765, 0, 1'b1,
           mk(1'b0, 1'b1, 5'd11, 32'hFFFF8765, 1'b0, 4'b0011, 32'h200, 32'h0));
    run_op(1'b1, 1'b0, WORD, 1'b1, 32'h010, 32'h0, 5'd12, 32'h80000001, 0, 1'b0,
           mk(1'b0, 1'b1, 5'd12, 32'h80000001, 1'b0, 4'hF, 32'h010, 32'h0));
  endtask

  task automatic test_misaligned();
    run_op(1'b0, 1'b1, HALF, 1'b0, 32'h301, 32'h1234, 5'd1, 32'h0, 0, 1'b0,
           mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0));
    run_op(1'b1, 1'b0, WORD, 1'b0, 32'h102, 32'h0, 5'd2, 32'h0, 0, 1'b0,
           mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0));
  endtask

  task automatic test_store_byte();
    run_op(1'b0, 1'b1, BYTE, 1'b0, 32'h002, 32'h000000AB, 5'd4, 32'h0, 0, 1'b0,
           mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 4'b0100, 32'h0, 32'hABABABAB));
  endtask

  task automatic test_no_flags();
    valid = 1'b1; rd = 1'b0; wr = 1'b0; mtype = WORD; addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1 || done !== 1'b0 || mem_req !== 1'b0 || mis !== 1'b0) begin
        miscompares++;
        $display("FAIL no_flags: ready=%b done=%b req=%b mis=%b want 1 0 0 0", ready, done, mem_req, mis);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int phase = 0; phase < 2; phase++) begin
      valid = 1'b1; rd = 1'b1; mtype = WORD; addr = 32'h400; rd_addr = 5'd5;
      step();
      valid = 1'b0; rd = 1'b0;
      if (phase == 1) begin
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
      end
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_before_rst: ready=%b want 0 (phase %0d)", ready, phase);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL async_rst: req=%b ready=%b want 0 1 (phase %0d)", mem_req, ready, phase);
      end
      step();
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || rf_we !== 1'b0 || ready !== 1'b1 || mem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL late_rvalid: done=%b rf_we=%b ready=%b req=%b want 0 0 1 0",
                   done, rf_we, ready, mem_req);
        end
        step();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, r, want;
      logic [7:0]  b;
      logic        s;
      a = 32'h800 + 32'($urandom_range(0, 3));
      r = $urandom;
      s = 1'($urandom_range(0, 1));
      b = r[8*a[1:0] +: 8];
      want = s ? {{24{b[7]}}, b} : {24'd0, b};
      run_op(1'b1, 1'b0, BYTE, s, a, 32'h0, 5'(i + 16), r, i % 2, (i % 3) == 0,
             mk(1'b0, 1'b1, 5'(i + 16), want, 1'b0, 4'b0001 << a[1:0], 32'h800, 32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half_same_cycle();
    test_misaligned();
    test_store_byte();
    test_no_flags();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/segre_lsu.md
Name: segre_lsu

Overview:
Load/store unit in the memory stage. It consumes the memop control produced by the decoder: rd/wr, data type, sign-extend, plus the ALU-computed address, store data and destination register. It runs the request/grant/response handshake to data memory and returns aligned, extended load data for register-file writeback. It stalls the pipeline while an access is in flight.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; only 32 is supported
REG_SIZE, 5, register address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  memop present in stage
memop_rd_i  in  1  load
memop_wr_i  in  1  store
memop_type_i  in  memop_data_type_e  BYTE/HALF/WORD
memop_sign_ext_i  in  1  sign-extend load result
addr_i  in  ADDR_WIDTH  effective byte address
wdata_i  in  DATA_WIDTH  store data, right-justified
rd_addr_i  in  REG_SIZE  load destination register
ready_o  out  1  LSU idle; can accept
stall_o  out  1  access in progress (equals ~ready_o)
done_o  out  1  one-cycle pulse when access completes
misaligned_o  out  1  one-cycle pulse, with done_o, for a misaligned access
rf_we_o  out  1  load-result write enable (pulse)
rf_waddr_o  out  REG_SIZE  writeback register
rf_wdata_o  out  DATA_WIDTH  extended load data
mem_req_o  out  1  memory request
mem_gnt_i  in  1  request accepted
mem_we_o  out  1  1 = write
mem_be_o  out  4  byte enables
mem_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
mem_wdata_o  out  DATA_WIDTH  lane-replicated store data
mem_rvalid_i  in  1  response/ack valid
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- States (lsu_state_e): IDLE, REQ, WAIT, RESP.
- Reset, asynchronous: state=IDLE. All outputs are 0 except ready_o=1. All captured registers are 0.
- Accept: in IDLE, when valid_i and (memop_rd_i or memop_wr_i), capture type, sign_ext, addr, wdata, rd_addr and we (= wr and not rd).
  - If rd and wr are both set, the access is a load.
  - valid_i with neither flag is ignored: the LSU stays in IDLE and raises no pulses.
- Misalignment: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
  - Go to RESP with misaligned_o=1.
  - No memory request is issued and rf_we_o stays 0.
- Aligned access: go to REQ. mem_req_o is 1 in REQ and holds mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o stable until mem_gnt_i.
  - gnt without rvalid: go to WAIT.
  - gnt and rvalid in the same cycle: go to RESP.
- WAIT: mem_req_o=0. On mem_rvalid_i, capture mem_rdata_i and go to RESP.
- RESP (one cycle): done_o=1. For loads, rf_we_o=1 with rf_waddr_o/rf_wdata_o valid. Then go to IDLE.
- Minimum latency, accept to done_o: 2 cycles with same-cycle gnt+rvalid, 3 otherwise. Minimum spacing between accepts is 3 cycles.
- Byte enables, with o = addr[1:0]:
  - BYTE: 4'b0001<<o
  - HALF: 4'b0011<<o
  - WORD: 4'b1111
- Store data:
  - BYTE: wdata[7:0] replicated ×4
  - HALF: wdata[15:0] replicated ×2
  - WORD: wdata unchanged
- Load data: shift mem_rdata right by 8*o, take the low 8/16/32 bits, then sign- or zero-extend per sign_ext. WORD ignores sign_ext.
- mem_rvalid_i outside WAIT/REQ is ignored. mem_gnt_i outside REQ is ignored.
- Reset mid-access: immediate IDLE and mem_req_o drops combinationally. A late rvalid is ignored.
- The pipeline must hold valid_i and its operands while stall_o=1. The LSU does not re-sample them.
- mem_addr_o = {addr[ADDR_WIDTH-1:2],2'b00}.

Decomposition:
- Existing shared package gains:
  - lsu_state_e (2-bit)
  - MEM_BE_WIDTH=4
  - memop_data_type_e: reused as-is
- Sub-module segre_lsu_align, purely combinational:
  - store path: type, offset, wdata -> be, wdata_rep
  - load path: type, offset, sign_ext, rdata -> extended data
- The FSM and capture registers remain in segre_lsu.

Test Plan:
1. Store WORD, addr=0x104, wdata=0xDEADBEEF, gnt after 2 cycles, rvalid +1 -> mem_be_o=4'hF, mem_addr_o=0x104, mem_we_o=1, done_o pulse, rf_we_o=0.
2. Load BYTE signed, addr=0x203, mem_rdata=0x80FF1234 -> mem_be_o=4'b1000, rf_wdata_o=0xFFFFFF80; same with unsigned -> 0x00000080.
3. Load HALF unsigned, addr=0x202, rdata=0xBEEF0000, same-cycle gnt+rvalid -> done_o exactly 2 cycles after accept, rf_wdata_o=0x0000BEEF.
4. Store HALF, addr=0x301 -> no mem_req_o, misaligned_o=done_o=1 for 1 cycle, then ready_o=1.
5. Store BYTE, addr=0x002, wdata=0x000000AB -> mem_wdata_o=0xABABABAB, mem_be_o=4'b0100.
6. Assert rst_i while in WAIT, then pulse mem_rvalid_i -> mem_req_o=0 at once, no done_o/rf_we_o, ready_o=1.
